// File: rtl/ex_pipe_pkg.sv
// ex_pipe_pkg: shared encodings for the execute stage.
//   Result classes (alusel), operation subtypes (aluop), default widths and
//   ZeroWord. These are the same codes the decoder emits; nothing new is
//   introduced here.
package ex_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [DATA_W-1:0] ZeroWord = '0;

  // Result classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  // Logic subtypes
  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27;

  // Shift subtypes (immediate and variable forms share datapaths)
  localparam logic [7:0] EXE_SLLV_OP = 8'h04;
  localparam logic [7:0] EXE_SRLV_OP = 8'h06;
  localparam logic [7:0] EXE_SRAV_OP = 8'h07;
  localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP  = 8'h02;
  localparam logic [7:0] EXE_SRA_OP  = 8'h03;

  localparam logic [7:0] EXE_NOP_OP  = 8'h00;

endpackage

// File: rtl/ex_pipe_alu.sv
// ex_alu: combinational logic/shift unit of the execute stage.
//   aluop_i  : operation subtype
//   alusel_i : result class (LOGIC or SHIFT; anything else yields 0)
//   reg1_i   : operand 1; its low 5 bits are the shift amount
//   reg2_i   : operand 2; the value being shifted
//   result_o : execute result
module ex_alu
  import ex_pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int OPW  = 8,
  parameter int SELW = 3
) (
  input  logic [OPW-1:0]  aluop_i,
  input  logic [SELW-1:0] alusel_i,
  input  logic [DW-1:0]   reg1_i,
  input  logic [DW-1:0]   reg2_i,
  output logic [DW-1:0]   result_o
);

  logic [4:0] sa;
  assign sa = reg1_i[4:0];

  always_comb begin
    result_o = '0;
    case (alusel_i)
      SELW'(EXE_RES_LOGIC): begin
        case (aluop_i)
          OPW'(EXE_OR_OP):  result_o = reg1_i | reg2_i;
          OPW'(EXE_AND_OP): result_o = reg1_i & reg2_i;
          OPW'(EXE_XOR_OP): result_o = reg1_i ^ reg2_i;
          OPW'(EXE_NOR_OP): result_o = ~(reg1_i | reg2_i);
          default:          result_o = '0;
        endcase
      end
      SELW'(EXE_RES_SHIFT): begin
        case (aluop_i)
          OPW'(EXE_SLL_OP), OPW'(EXE_SLLV_OP): result_o = reg2_i << sa;
          OPW'(EXE_SRL_OP), OPW'(EXE_SRLV_OP): result_o = reg2_i >> sa;
          // Sign fill comes from the operand MSB.
          OPW'(EXE_SRA_OP), OPW'(EXE_SRAV_OP): result_o = DW'($signed(reg2_i) >>> sa);
          default:                             result_o = '0;
        endcase
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_pipe.sv
// ex_pipe: execute stage of the five-stage MIPS core.
//   ID/EX register -> ex_alu -> EX/MEM register.
//   Inputs : clk, rst (sync, active-high), id_* decoded op and operands,
//            id/ex/mem stall controls.
//   Outputs: ex_*  combinational EX result (forward port 1)
//            mem_* registered EX/MEM result (memory stage and forward port 2)
//
// Stall semantics: a stage that is stalled holds its register; the stage
// directly downstream of a stalled stage loads a bubble, so a held operation
// leaves exactly once when the stall releases. The stall controller only
// produces mem_stall -> ex_stall -> id_stall nested combinations.
module ex_pipe
  import ex_pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  id_aluop_i,
  input  logic [SELW-1:0] id_alusel_i,
  input  logic [DW-1:0]   id_reg1_i,
  input  logic [DW-1:0]   id_reg2_i,
  input  logic [AW-1:0]   id_wd_i,
  input  logic            id_wreg_i,
  input  logic            id_stall_i,
  input  logic            ex_stall_i,
  input  logic            mem_stall_i,
  output logic            ex_wreg_o,
  output logic [AW-1:0]   ex_wd_o,
  output logic [DW-1:0]   ex_wdata_o,
  output logic            mem_wreg_o,
  output logic [AW-1:0]   mem_wd_o,
  output logic [DW-1:0]   mem_wdata_o
);

  // ID/EX register
  logic [OPW-1:0]  idex_aluop_q,  idex_aluop_d;
  logic [SELW-1:0] idex_alusel_q, idex_alusel_d;
  logic [DW-1:0]   idex_reg1_q,   idex_reg1_d;
  logic [DW-1:0]   idex_reg2_q,   idex_reg2_d;
  logic [AW-1:0]   idex_wd_q,     idex_wd_d;
  logic            idex_wreg_q,   idex_wreg_d;

  // EX/MEM register
  logic            exmem_wreg_q,  exmem_wreg_d;
  logic [AW-1:0]   exmem_wd_q,    exmem_wd_d;
  logic [DW-1:0]   exmem_wdata_q, exmem_wdata_d;

  logic [DW-1:0]   alu_result;

  always_comb begin
    idex_aluop_d  = idex_aluop_q;
    idex_alusel_d = idex_alusel_q;
    idex_reg1_d   = idex_reg1_q;
    idex_reg2_d   = idex_reg2_q;
    idex_wd_d     = idex_wd_q;
    idex_wreg_d   = idex_wreg_q;
    if (rst) begin
      idex_aluop_d  = '0;
      idex_alusel_d = '0;
      idex_reg1_d   = '0;
      idex_reg2_d   = '0;
      idex_wd_d     = '0;
      idex_wreg_d   = 1'b0;
    end else if (ex_stall_i) begin
      // hold
    end else if (id_stall_i) begin
      idex_aluop_d  = '0;
      idex_alusel_d = '0;
      idex_reg1_d   = '0;
      idex_reg2_d   = '0;
      idex_wd_d     = '0;
      idex_wreg_d   = 1'b0;
    end else begin
      idex_aluop_d  = id_aluop_i;
      idex_alusel_d = id_alusel_i;
      idex_reg1_d   = id_reg1_i;
      idex_reg2_d   = id_reg2_i;
      idex_wd_d     = id_wd_i;
      idex_wreg_d   = id_wreg_i;
    end
  end

  always_ff @(posedge clk) begin
    idex_aluop_q  <= idex_aluop_d;
    idex_alusel_q <= idex_alusel_d;
    idex_reg1_q   <= idex_reg1_d;
    idex_reg2_q   <= idex_reg2_d;
    idex_wd_q     <= idex_wd_d;
    idex_wreg_q   <= idex_wreg_d;
  end

  ex_alu #(
    .DW   (DW),
    .OPW  (OPW),
    .SELW (SELW)
  ) u_ex_alu (
    .aluop_i  (idex_aluop_q),
    .alusel_i (idex_alusel_q),
    .reg1_i   (idex_reg1_q),
    .reg2_i   (idex_reg2_q),
    .result_o (alu_result)
  );

  // r0 is hardwired zero: a write to it is neither forwarded nor committed.
  assign ex_wd_o    = idex_wd_q;
  assign ex_wdata_o = alu_result;
  assign ex_wreg_o  = idex_wreg_q && (idex_wd_q != '0);

  always_comb begin
    exmem_wreg_d  = exmem_wreg_q;
    exmem_wd_d    = exmem_wd_q;
    exmem_wdata_d = exmem_wdata_q;
    if (rst) begin
      exmem_wreg_d  = 1'b0;
      exmem_wd_d    = '0;
      exmem_wdata_d = '0;
    end else if (mem_stall_i) begin
      // hold
    end else if (ex_stall_i) begin
      exmem_wreg_d  = 1'b0;
      exmem_wd_d    = '0;
      exmem_wdata_d = '0;
    end else begin
      exmem_wreg_d  = ex_wreg_o;
      exmem_wd_d    = ex_wd_o;
      exmem_wdata_d = ex_wdata_o;
    end
  end

  always_ff @(posedge clk) begin
    exmem_wreg_q  <= exmem_wreg_d;
    exmem_wd_q    <= exmem_wd_d;
    exmem_wdata_q <= exmem_wdata_d;
  end

  assign mem_wreg_o  = exmem_wreg_q;
  assign mem_wd_o    = exmem_wd_q;
  assign mem_wdata_o = exmem_wdata_q;

endmodule
